fetch_stage: RTL and testbench
==============================

# fetch_stage

Parametrised instruction fetch stage for the rapid CPU, filling the slot that currently drives the decoder's instruction and PC inputs by hand. It issues word reads to instruction memory over a req/ack handshake, buffers fetched instructions in a DEPTH-entry prefetch queue, and hands them to the decode stage under `i_pipeline_ready`. On an execute-stage redirect (`o_pc_load` / `o_pc_ext` from `execute_stage`), it flushes and refetches from the new target.

## Interface
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2
- `BOOT_PC`, `RESET_VECTOR` (package), fetch address after reset
- `i_clk`  in  1  clock; all state updates on its rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_pipeline_ready`  in  1  decode accepts `o_instruction`/`o_pc` this cycle
- `i_pc_load`  in  1  redirect request from EX
- `i_pc_ext`  in  XLEN  redirect target
- `o_mem_req`  out  1  instruction memory read request
- `o_mem_addr`  out  XLEN  word-aligned read address
- `i_mem_ack`  in  1  read data valid; completes the request
- `i_mem_rdata`  in  32  instruction word
- `o_instruction`  out  32  head-of-queue instruction, or NOP when empty
- `o_pc`  out  XLEN  PC of `o_instruction`
- `o_valid`  out  1  queue head valid
- `o_misaligned`  out  1  one-cycle pulse: redirect target had bits[1:0]≠0

## Operation
- **States** (`fetch_state_e`):
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - DISCARD: outstanding request whose data must be dropped.
- **Issue rule:** start a request only when `count + outstanding < DEPTH`. The queue therefore never overflows and never needs backpressure toward memory.
- **Request handshake:**
  - `o_mem_req` and `o_mem_addr` are registered and held stable until the cycle `i_mem_ack`=1.
  - The ack may arrive in the first req cycle (zero wait) or after any number of cycles.
- **Ack handling:**
  - In WAIT, on ack: push {`fetch_pc`, `i_mem_rdata`} and set `fetch_pc` += 4.
  - If the issue rule still holds, counting a same-cycle pop, `o_mem_req` stays 1 with the new address; otherwise go to IDLE.
- **Pop:** `i_pipeline_ready & o_valid` advances the head. `i_pipeline_ready` while empty has no effect; `o_instruction` stays NOP (32'h00000013).
- **Push and pop in the same cycle:** count unchanged; legal when full.
- **Redirect** (`i_pc_load`=1):
  - Queue flushes and `fetch_pc` is set to {`i_pc_ext`[XLEN-1:2], 2'b00}.
  - `o_misaligned` pulses when `i_pc_ext`[1:0]≠0.
  - A redirect in IDLE issues a request to the target in the next cycle.
  - A redirect in WAIT without a same-cycle ack goes to DISCARD. The request stays asserted at the old address until ack; the data is dropped; the next cycle requests the target.
  - A redirect in WAIT with a same-cycle ack drops that data and goes directly to requesting the target.
- **Simultaneous events:**
  - Redirect overrides pop and push: next cycle `o_valid`=0.
  - A second redirect in DISCARD updates the target only.
- **Pointer and PC arithmetic:**
  - Queue pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is $clog2(DEPTH)+1 bits.
  - `fetch_pc` wraps modulo 2^XLEN.

## Timing
- **Reset values:**
  - `o_mem_req`=0, `o_mem_addr`=`BOOT_PC`.
  - `o_valid`=0, `o_instruction`=NOP, `o_pc`=`BOOT_PC`.
  - `o_misaligned`=0, state IDLE, count 0.
- **Reset mid-operation:** reset in any state, including DISCARD, returns to these values at the next edge. An in-flight ack arriving after reset is ignored.
- **First request:** `o_mem_req` rises at the first edge with `i_reset`=0.
- **Fetch latency:**
  - Ack in cycle k → `o_valid`=1 and `o_instruction` valid in cycle k+1.
  - With zero-wait memory, the first instruction is visible 2 cycles after reset deassertion.
  - Sustained throughput is 1 instruction/cycle.
- **Redirect latency:**
  - Redirect in cycle r from IDLE or WAIT+ack → `o_mem_addr`=target in r+1.
  - From DISCARD → target request the cycle after the stale ack.
- **Output path:** `o_instruction`, `o_pc` and `o_valid` are driven from registers and queue storage only, with no combinational path from `i_mem_*`.

## Structure
- Add to `rapid_pkg`:
  - `NOP_INSTR` constant (32'h00000013).
  - `fetch_state_e` enum {IDLE, WAIT, DISCARD}.
  - `fetch_entry_s` struct {pc, instruction}.
- Reuse `XLEN` and `RESET_VECTOR` from `rapid_pkg`.
- One sub-module, `fetch_fifo`:
  - Synchronous FIFO of `fetch_entry_s`, parametrised `DEPTH`.
  - Ports: push, pop, flush (flush dominant), full, empty, count.
- `fetch_stage` holds the FSM, `fetch_pc`, and the issue/redirect logic.

## Test plan
- **Reset:** reset 1 cycle, zero-wait memory returning 32'h00a00193 at `RESET_VECTOR` → cycle 2 after release `o_valid`=1, `o_instruction`=32'h00a00193, `o_pc`=`RESET_VECTOR`.
- **Fill:** `i_pipeline_ready`=0, DEPTH=4 → exactly 4 acks, then `o_mem_req`=0. Queue holds PCs V, V+4, V+8, V+12, and `o_valid` stays 1.
- **Streaming:** constant `i_pipeline_ready`=1 with zero-wait memory → one pop per cycle, consecutive PCs, no bubbles after the first.
- **Redirect while waiting:** 3-cycle ack latency, redirect to 32'h0000_0100 in cycle 1 of the wait.
  - The stale word is dropped and the next request has `o_mem_addr`=32'h100.
  - The first valid `o_pc` is 32'h100.
- **Misaligned redirect:** target 32'h0000_0102 → `o_misaligned` pulses 1 cycle; fetch proceeds from 32'h100.
- **Reset during DISCARD:** → all outputs return to reset values next cycle, the late ack is ignored, and fetch restarts at `RESET_VECTOR`.

Source files
------------

// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared rapid CPU constants and fetch stage types
package rapid_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0200;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
    } fetch_entry_s;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_s);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch queue of fetch entries, flush dominant
module fetch_fifo
    import rapid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [FETCH_ENTRY_W-1:0]   i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [FETCH_ENTRY_W-1:0]   o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [FETCH_ENTRY_W-1:0] mem_q [DEPTH];
    logic [FETCH_ENTRY_W-1:0] mem_d [DEPTH];
    logic do_push, do_pop;

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = i_pop & (count_q != '0);
    assign do_push = i_push & ((count_q != DEPTH_C) | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == DEPTH_C);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: memory request FSM, prefetch queue, redirect handling
module fetch_stage
    import rapid_pkg::*;
#(
    parameter int              DEPTH   = 4,
    parameter logic [XLEN-1:0] BOOT_PC = RESET_VECTOR
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_pipeline_ready,
    input  logic            i_pc_load,
    input  logic [XLEN-1:0] i_pc_ext,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_ack,
    input  logic [31:0]     i_mem_rdata,
    output logic [31:0]     o_instruction,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid,
    output logic            o_misaligned
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misaligned_q, misaligned_d;

    logic               push, pop, flush, ack;
    logic               fifo_full, fifo_empty;
    logic [PW:0]        fifo_count, count_after_push;
    logic [XLEN-1:0]    target, next_pc;
    fetch_entry_s       push_entry, head_entry;
    logic [FETCH_ENTRY_W-1:0] head_raw;

    assign ack              = i_mem_ack & req_q;
    assign pop              = i_pipeline_ready & ~fifo_empty;
    assign push             = (state_q == WAIT) & ack & ~i_pc_load;
    assign count_after_push = fifo_count + 1'b1 - {{PW{1'b0}}, pop};
    assign target           = {i_pc_ext[XLEN-1:2], 2'b00};
    assign next_pc          = fetch_pc_q + XLEN'(4);
    assign push_entry       = '{pc: fetch_pc_q, instruction: i_mem_rdata};
    assign head_entry       = fetch_entry_s'(head_raw);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (push),
        .i_push_data (push_entry),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_head      (head_raw),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            addr_q       <= BOOT_PC;
            fetch_pc_q   <= BOOT_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            fetch_pc_q   <= fetch_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        fetch_pc_d   = fetch_pc_q;
        misaligned_d = 1'b0;
        flush        = 1'b0;
        if (i_pc_load) begin
            flush        = 1'b1;
            fetch_pc_d   = target;
            misaligned_d = |i_pc_ext[1:0];
            // Without an ack the old request must still complete; its data is dropped in DISCARD.
            if (state_q == IDLE || ack) begin
                state_d = WAIT;
                req_d   = 1'b1;
                addr_d  = target;
            end else begin
                state_d = DISCARD;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full || pop) begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        fetch_pc_d = next_pc;
                        if (count_after_push < DEPTH_C) begin
                            addr_d = next_pc;
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state_d = WAIT;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_mem_req     = req_q;
        o_mem_addr    = addr_q;
        o_misaligned  = misaligned_q;
        o_valid       = ~fifo_empty;
        o_instruction = fifo_empty ? NOP_INSTR : head_entry.instruction;
        o_pc          = fifo_empty ? fetch_pc_q : head_entry.pc;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] V   = rapid_pkg::RESET_VECTOR;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipeline_ready = 1'b0;
    logic        i_pc_load = 1'b0;
    logic [31:0] i_pc_ext = '0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        o_misaligned;

    int tests = 0;
    int failed = 0;
    int mem_wait = 0;
    int mem_cnt = 0;
    int ack_count = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(4)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_pipeline_ready (i_pipeline_ready),
        .i_pc_load        (i_pc_load),
        .i_pc_ext         (i_pc_ext),
        .o_mem_req        (o_mem_req),
        .o_mem_addr       (o_mem_addr),
        .i_mem_ack        (i_mem_ack),
        .i_mem_rdata      (i_mem_rdata),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_valid          (o_valid),
        .o_misaligned     (o_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ V ^ 32'h00a0_0193;
    endfunction

    // Advance to the falling edge, then play the memory for the cycle ahead.
    task automatic step();
        @(negedge clk);
        if (o_mem_req) begin
            if (mem_cnt >= mem_wait) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_word(o_mem_addr);
                mem_cnt     = 0;
                ack_count++;
            end else begin
                i_mem_ack = 1'b0;
                mem_cnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            mem_cnt   = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_req", o_mem_req, 0);
        chk("rst_addr", o_mem_addr, V);
        chk("rst_valid", o_valid, 0);
        chk("rst_instr", o_instruction, NOP);
        chk("rst_pc", o_pc, V);
        chk("rst_mis", o_misaligned, 0);

        i_reset = 1'b0;
        step();
        chk("first_req", o_mem_req, 1);
        chk("first_addr", o_mem_addr, V);
        chk("first_novalid", o_valid, 0);
        step();
        chk("first_valid", o_valid, 1);
        chk("first_instr", o_instruction, 32'h00a0_0193);
        chk("first_pc", o_pc, V);

        for (int i = 0; i < 5; i++) step();
        chk("fill_req_off", o_mem_req, 0);
        chk("fill_acks", ack_count, 4);
        chk("fill_valid", o_valid, 1);
        chk("fill_head_pc", o_pc, V);

        i_pipeline_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("stream_valid", o_valid, 1);
            chk("stream_pc", o_pc, V + 32'(4 * i));
            chk("stream_instr", o_instruction, mem_word(V + 32'(4 * i)));
        end

        i_reset = 1'b1;
        mem_wait = 3;
        step();
        i_reset = 1'b0;
        step();
        chk("rw_req", o_mem_req, 1);
        i_pc_load = 1'b1;
        i_pc_ext = 32'h0000_0100;
        step();
        i_pc_load = 1'b0;
        chk("rw_hold_addr", o_mem_addr, V);
        chk("rw_hold_req", o_mem_req, 1);
        chk("rw_novalid", o_valid, 0);
        step();
        step();
        step();
        chk("rw_target_addr", o_mem_addr, 32'h0000_0100);
        chk("rw_target_req", o_mem_req, 1);
        chk("rw_stale_dropped", o_valid, 0);
        chk("rw_empty_nop", o_instruction, NOP);
        for (int k = 0; k < 20 && !o_valid; k++) step();
        chk("rw_valid", o_valid, 1);
        chk("rw_pc", o_pc, 32'h0000_0100);
        chk("rw_instr", o_instruction, mem_word(32'h0000_0100));

        mem_wait = 0;
        step();
        i_pc_load = 1'b1;
        i_pc_ext = 32'h0000_0102;
        step();
        i_pc_load = 1'b0;
        chk("mis_pulse", o_misaligned, 1);
        chk("mis_addr", o_mem_addr, 32'h0000_0100);
        chk("mis_flushed", o_valid, 0);
        step();
        chk("mis_pulse_end", o_misaligned, 0);
        chk("mis_valid", o_valid, 1);
        chk("mis_pc", o_pc, 32'h0000_0100);

        i_reset = 1'b1;
        mem_wait = 5;
        step();
        i_reset = 1'b0;
        step();
        i_pc_load = 1'b1;
        i_pc_ext = 32'h0000_0300;
        step();
        i_pc_load = 1'b0;
        chk("rd_discard_addr", o_mem_addr, V);
        i_reset = 1'b1;
        step();
        chk("rd_req", o_mem_req, 0);
        chk("rd_addr", o_mem_addr, V);
        chk("rd_valid", o_valid, 0);
        chk("rd_instr", o_instruction, NOP);
        chk("rd_pc", o_pc, V);
        chk("rd_mis", o_misaligned, 0);
        i_reset = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hdead_beef;
        mem_wait = 0;
        step();
        chk("rd_late_ack_ignored", o_valid, 0);
        chk("rd_restart_req", o_mem_req, 1);
        chk("rd_restart_addr", o_mem_addr, V);
        step();
        chk("rd_restart_valid", o_valid, 1);
        chk("rd_restart_pc", o_pc, V);
        chk("rd_restart_instr", o_instruction, 32'h00a0_0193);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
